// File: rtl/nanaseg_pkg.sv
// Shared constants and types for the seven-segment readback checkers.
package nanaseg_pkg;

  // Active-low segment fields for digits 0..9, select bits already masked off
  localparam logic [11:0] SEG_0 = 12'h014;
  localparam logic [11:0] SEG_1 = 12'h617;
  localparam logic [11:0] SEG_2 = 12'h20C;
  localparam logic [11:0] SEG_3 = 12'h205;
  localparam logic [11:0] SEG_4 = 12'h407;
  localparam logic [11:0] SEG_5 = 12'h045;
  localparam logic [11:0] SEG_6 = 12'h044;
  localparam logic [11:0] SEG_7 = 12'h017;
  localparam logic [11:0] SEG_8 = 12'h004;
  localparam logic [11:0] SEG_9 = 12'h005;

  localparam int unsigned SEL_ONES = 7;
  localparam int unsigned SEL_TENS = 8;
  localparam int unsigned SEL_HUND = 11;

  localparam logic [11:0] SEG_MASK = 12'h67F;
  localparam logic [11:0] SEL_MASK = 12'h980;

  typedef enum logic [1:0] {
    SYNC,
    EXP_TENS,
    EXP_HUND
  } scan_state_e;

endpackage

// File: rtl/nanaseg_readback_if.sv
// Display bus plus readback results; slave is the checker, master the observer.
interface nanaseg_readback_if;
  logic [11:0] seg_in;
  logic [9:0]  value;
  logic        value_valid;
  logic        pattern_err;
  logic        seq_err;
  logic        stale;
  logic [7:0]  err_count;

  modport slave (
    input  seg_in,
    output value, value_valid, pattern_err, seq_err, stale, err_count
  );

  modport master (
    output seg_in,
    input  value, value_valid, pattern_err, seq_err, stale, err_count
  );
endinterface

// File: rtl/nanaseg_pattern_decode.sv
// Maps an active-low segment field back to its BCD digit; anything else is illegal.
module nanaseg_pattern_decode
  import nanaseg_pkg::*;
(
  input  logic [11:0] seg_field,
  output logic        legal,
  output logic [3:0]  bcd
);

  // Exact match against the ten legal patterns (decimal point and bit 5 included)
  always_comb begin
    legal = 1'b1;
    bcd   = 4'd0;
    case (seg_field & SEG_MASK)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/nanaseg_readback.sv
// Reconstructs the displayed 3-digit value from the scanned segment bus and
// reports illegal patterns, out-of-order scans and stalled scanning.
module nanaseg_readback
  import nanaseg_pkg::*;
#(
  parameter int unsigned STABLE_SCANS   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              CLOCK10M,
  input  logic              RESET_N,
  nanaseg_readback_if.slave bus
);

  localparam logic [3:0]  STABLE_W  = 4'(STABLE_SCANS);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

  logic [11:0] seg_q;
  logic        legal;
  logic [3:0]  bcd;
  logic [2:0]  sel;
  logic        idle, illegal, is_ones, is_tens, is_hund;

  scan_state_e state, state_d;
  logic        ld_ones, ld_tens, done_d, serr_d;
  logic [3:0]  ones_q, tens_q;
  logic [9:0]  v_d;

  logic        done_q, perr_q, serr_q;
  logic [9:0]  v_q, prev_v;
  logic [3:0]  match_cnt, match_d;
  logic        published, publish;
  logic [15:0] to_cnt;

  logic [9:0]  value_q;
  logic        value_valid_q, pattern_err_q, seq_err_q, stale_q;
  logic [7:0]  err_count_q;

  // Input capture register
  always_ff @(posedge CLOCK10M or negedge RESET_N) begin
    if (!RESET_N) seg_q <= '0;
    else          seg_q <= bus.seg_in;
  end

  nanaseg_pattern_decode u_decode (
    .seg_field (seg_q),
    .legal     (legal),
    .bcd       (bcd)
  );

  // Classify the captured sample by its select bits and segment legality
  always_comb begin
    sel     = {seg_q[SEL_HUND], seg_q[SEL_TENS], seg_q[SEL_ONES]};
    idle    = (sel == 3'b000);
    illegal = !idle && (!legal || !(sel == 3'b001 || sel == 3'b010 || sel == 3'b100));
    is_ones = !illegal && (sel == 3'b001);
    is_tens = !illegal && (sel == 3'b010);
    is_hund = !illegal && (sel == 3'b100);
  end

  // Scan FSM state register
  always_ff @(posedge CLOCK10M or negedge RESET_N) begin
    if (!RESET_N) state <= SYNC;
    else          state <= state_d;
  end

  // Scan FSM next state
  always_comb begin
    state_d = state;
    if (illegal) begin
      state_d = SYNC;
    end else begin
      case (state)
        SYNC:     if (is_ones) state_d = EXP_TENS;
        EXP_TENS: if (is_tens) state_d = EXP_HUND;
                  else if (is_hund) state_d = SYNC;
        EXP_HUND: if (is_hund) state_d = SYNC;
                  else if (is_ones) state_d = EXP_TENS;
        default:  state_d = SYNC;
      endcase
    end
  end

  // Scan FSM outputs: digit loads, scan completion and order violations
  always_comb begin
    ld_ones = is_ones;
    ld_tens = is_tens && (state == EXP_TENS || state == EXP_HUND);
    done_d  = is_hund && (state == EXP_HUND);
    serr_d  = (is_hund && state == EXP_TENS) || (is_ones && state == EXP_HUND);
    v_d     = 10'(bcd) * 10'd100 + 10'(tens_q) * 10'd10 + 10'(ones_q);
  end

  // Digit storage and the second pipeline stage
  always_ff @(posedge CLOCK10M or negedge RESET_N) begin
    if (!RESET_N) begin
      ones_q <= '0;
      tens_q <= '0;
      done_q <= 1'b0;
      perr_q <= 1'b0;
      serr_q <= 1'b0;
      v_q    <= '0;
    end else begin
      if (ld_ones) ones_q <= bcd;
      if (ld_tens) tens_q <= bcd;
      done_q <= done_d;
      perr_q <= illegal;
      serr_q <= serr_d;
      v_q    <= v_d;
    end
  end

  // Stability counting and publish decision for a completed scan
  always_comb begin
    match_d = match_cnt;
    if (perr_q || serr_q) begin
      match_d = '0;
    end else if (done_q) begin
      if (v_q != prev_v)             match_d = 4'd1;
      else if (match_cnt < STABLE_W) match_d = match_cnt + 4'd1;
    end
    publish = done_q && (match_d == STABLE_W) && (v_q != value_q || !published);
  end

  // Registered outputs, error accounting and stall timer
  always_ff @(posedge CLOCK10M or negedge RESET_N) begin
    if (!RESET_N) begin
      match_cnt     <= '0;
      prev_v        <= '0;
      published     <= 1'b0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      seq_err_q     <= 1'b0;
      err_count_q   <= '0;
      to_cnt        <= '0;
      stale_q       <= 1'b0;
    end else begin
      match_cnt     <= match_d;
      value_valid_q <= publish;
      pattern_err_q <= perr_q;
      seq_err_q     <= serr_q;
      if (done_q) prev_v <= v_q;
      if (publish) begin
        value_q   <= v_q;
        published <= 1'b1;
      end
      if ((perr_q || serr_q) && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      if (done_q) begin
        to_cnt  <= '0;
        stale_q <= 1'b0;
      end else begin
        if (to_cnt != TIMEOUT_W)           to_cnt  <= to_cnt + 16'd1;
        if (to_cnt == TIMEOUT_W - 16'd1)   stale_q <= 1'b1;
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.stale       = stale_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_nanaseg_readback.sv
// Scoreboard bench for nanaseg_readback: stimulus pushes expected publications
// and error pulses, a monitor pops and compares them as the DUT emits them.
module tb_nanaseg_readback;

  logic CLOCK10M = 1'b0;
  logic RESET_N  = 1'b0;

  nanaseg_readback_if bus ();

  nanaseg_readback #(
    .STABLE_SCANS   (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLOCK10M (CLOCK10M),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  always #5 CLOCK10M = ~CLOCK10M;

  int applied     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int first_vv    = -1;
  int rel         = 0;
  int exp_val[$];
  int exp_err[$];   // 1 = pattern_err, 2 = seq_err

  task automatic check(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare each pulse against the head of the matching queue
  always @(posedge CLOCK10M) begin
    int code;
    #1;
    cyc++;
    if (bus.value_valid) begin
      if (first_vv < 0) first_vv = cyc;
      if (exp_val.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_value_valid: got value %0d, expected no pulse", bus.value);
      end else begin
        check("published_value", int'(bus.value), exp_val.pop_front());
      end
    end
    if (bus.pattern_err || bus.seq_err) begin
      code = (bus.pattern_err ? 1 : 0) + (bus.seq_err ? 2 : 0);
      if (exp_err.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_error_pulse: got kind %0d, expected none", code);
      end else begin
        check("error_pulse_kind", code, exp_err.pop_front());
      end
    end
  end

  task automatic drive(input logic [11:0] w);
    @(negedge CLOCK10M);
    bus.seg_in = w;
  endtask

  task automatic scan(input logic [11:0] o, input logic [11:0] t, input logic [11:0] h);
    drive(o);
    drive(t);
    drive(h);
  endtask

  task automatic scan123();
    scan(12'h285, 12'h30C, 12'hE17);
  endtask

  task automatic scan999();
    scan(12'h085, 12'h105, 12'h805);
  endtask

  task automatic drain();
    repeat (3) drive(12'h000);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"},       int'(bus.value),       0);
    check({tag, "_value_valid"}, int'(bus.value_valid), 0);
    check({tag, "_pattern_err"}, int'(bus.pattern_err), 0);
    check({tag, "_seq_err"},     int'(bus.seq_err),     0);
    check({tag, "_stale"},       int'(bus.stale),       0);
    check({tag, "_err_count"},   int'(bus.err_count),   0);
  endtask

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.seg_in = '0;
    #12;
    check_all_zero("reset");

    // Release and scan 123 continuously; exactly one publication
    @(negedge CLOCK10M);
    RESET_N    = 1'b1;
    rel        = cyc;
    first_vv   = -1;
    exp_val.push_back(123);
    bus.seg_in = 12'h285;
    drive(12'h30C);
    drive(12'hE17);
    repeat (11) scan123();
    check("first_valid_by_cycle9", int'(first_vv > rel && first_vv - rel <= 9), 1);
    check("pending_after_123", exp_val.size(), 0);
    check("value_123", int'(bus.value), 123);

    // Switch to 999: single publication after two complete scans
    exp_val.push_back(999);
    repeat (4) scan999();
    drain();
    check("pending_after_999", exp_val.size(), 0);
    check("value_999", int'(bus.value), 999);

    // Back to 123 as the baseline for the error cases
    exp_val.push_back(123);
    repeat (3) scan123();
    drain();
    check("value_back_123", int'(bus.value), 123);

    // Illegal tens sample (two selects): pattern_err, value held, no republish
    exp_err.push_back(1);
    drive(12'h285);
    drive(12'h1FF);
    drive(12'hE17);
    repeat (3) scan123();
    drain();
    check("pattern_err_seen", exp_err.size(), 0);
    check("err_count_after_pattern", int'(bus.err_count), 1);
    check("value_held_123", int'(bus.value), 123);

    // Ones then hundreds: seq_err, and publication of 999 needs two fresh scans
    scan999();
    drive(12'h285);
    exp_err.push_back(2);
    drive(12'hE17);
    scan999();
    drain();
    check("no_publish_one_scan_after_seq_err", int'(bus.value), 123);
    exp_val.push_back(999);
    scan999();
    drain();
    check("seq_err_seen", exp_err.size(), 0);
    check("pending_after_seq_err", exp_val.size(), 0);
    check("value_999_after_seq_err", int'(bus.value), 999);
    check("err_count_after_seq", int'(bus.err_count), 2);

    // Stall: stale rises after 16 cycles without a completed scan
    repeat (5) drive(12'h000);
    check("stale_low_early", int'(bus.stale), 0);
    repeat (12) drive(12'h000);
    check("stale_high", int'(bus.stale), 1);
    check("value_held_while_stale", int'(bus.value), 999);
    scan999();
    @(posedge CLOCK10M); #1;
    @(posedge CLOCK10M); #1;
    check("stale_held_until_done", int'(bus.stale), 1);
    @(posedge CLOCK10M); #1;
    check("stale_cleared_after_scan", int'(bus.stale), 0);
    check("value_after_stale", int'(bus.value), 999);

    // Asynchronous reset mid-scan, then republish 123
    drive(12'h285);
    #2;
    RESET_N = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge CLOCK10M);
    RESET_N    = 1'b1;
    rel        = cyc;
    first_vv   = -1;
    exp_val.push_back(123);
    bus.seg_in = 12'h285;
    drive(12'h30C);
    drive(12'hE17);
    repeat (3) scan123();
    drain();
    check("republish_by_cycle9", int'(first_vv > rel && first_vv - rel <= 9), 1);
    check("pending_after_reset", exp_val.size(), 0);
    check("value_after_reset", int'(bus.value), 123);
    check("err_count_after_reset", int'(bus.err_count), 0);
    check("pending_errors_end", exp_err.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/nanaseg_readback.md
# nanaseg_readback

Monitors the multiplexed 12-bit seven-segment drive bus (three digits, active-low segments, active-high digit selects) and turns the scanned patterns back into a binary display value. It sits beside the display driver, on the same bus, and gives the score logic a self-check path. It also flags illegal segment patterns, out-of-order digit scans and a stalled scan. A value is published only after a configurable number of identical complete scans.

## Interface
- `STABLE_SCANS`, default 2: consecutive identical complete scans required before publishing (1..15).
- `TIMEOUT_CYCLES`, default 16: cycles without a completed scan before `stale` asserts (3..65535).
- `CLOCK10M` in 1: the single clock; all logic on its rising edge.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `seg_in` in 12: display bus as driven to the pins.
- `value` out 10: last published value, 0..999.
- `value_valid` out 1: one-cycle pulse when `value` changes.
- `pattern_err` out 1: one-cycle pulse on an illegal sample.
- `seq_err` out 1: one-cycle pulse on a digit-order violation.
- `stale` out 1: level, high while the scan is stalled.
- `err_count` out 8: saturating count of erroneous samples.

## Operation
- **Bus format**
  - Select bits: 7 = ones, 8 = tens, 11 = hundreds.
  - Segment field: all other bits (mask 0x67F), active-low. Bit 5 must be 0 and bit 2 (decimal point) must be 1.
  - Legal segment fields for digits 0..9: 0x014, 0x617, 0x20C, 0x205, 0x407, 0x045, 0x044, 0x017, 0x004, 0x005.
- **Sample classification** (applied to the registered `seg_q`)
  - No select bit set: idle. Ignored, and no error.
  - More than one select bit set, or a segment field not in the table: illegal. Pulse `pattern_err` and go to SYNC.
  - Otherwise: a digit sample (position, BCD value).
- **Scan FSM**
  - States: SYNC, EXP_TENS, EXP_HUND.
  - SYNC: a ones sample stores the ones digit and goes to EXP_TENS. Tens or hundreds samples are ignored; they are not an error while unsynchronised.
  - EXP_TENS: a tens sample stores the digit and goes to EXP_HUND. A repeated ones sample overwrites the ones digit and stays in EXP_TENS. A hundreds sample pulses `seq_err` and goes to SYNC.
  - EXP_HUND: a hundreds sample completes the scan and goes to SYNC. A repeated tens sample overwrites and stays. A ones sample pulses `seq_err`, stores that ones digit and goes to EXP_TENS.
  - Idle samples never change state.
- **Completed scan**
  - Compute v = 100·h + 10·t + o.
  - If v equals the previous scan's v, `match_cnt` increments, saturating at `STABLE_SCANS`. Otherwise `match_cnt` = 1.
  - When `match_cnt` reaches `STABLE_SCANS` and either v ≠ `value` or nothing has been published since reset: load `value` and pulse `value_valid`.
- **Errors and stall**
  - Any `pattern_err` or `seq_err` clears `match_cnt` to 0.
  - `err_count` adds 1 per erroneous sample and saturates at 255.
  - `pattern_err` takes priority: one sample raises at most one error pulse.
- **Timeout**
  - Cycle counter is cleared on each completed scan.
  - `stale` asserts when the counter reaches `TIMEOUT_CYCLES`.
  - `stale` clears on the next completed scan. `value` is held throughout.

## Timing
- Reset values: `value` 0, `value_valid` 0, `pattern_err` 0, `seq_err` 0, `stale` 0, `err_count` 0.
- Internal reset: FSM in SYNC, `match_cnt` 0, published flag 0, timeout counter 0.
- `RESET_N` low mid-scan clears every output immediately, without waiting for a clock edge. Operation resumes in SYNC on the first edge after release.
- Latency: `seg_in` is captured at edge k, the FSM acts at edge k+1, and `value`/`value_valid`/error pulses update at edge k+2.
- All outputs are registered.
- Driven by a 3-cycle scanner starting on ones with `STABLE_SCANS`=2, the first `value_valid` occurs no later than cycle 9 after reset release.

## Structure
- Shared package `nanaseg_pkg` holds:
  - the ten segment-pattern constants;
  - select-bit indices 7/8/11, the segment mask 0x67F and the select mask 0x980;
  - the FSM state enum.
- Sub-module `nanaseg_pattern_decode`: combinational, segment field in, {legal, bcd[3:0]} out. It is reusable by other display checkers.

## Test plan
- Reset, then cycle 0x285, 0x30C, 0xE17 (score 123) → one `value_valid` pulse by cycle 9 with `value`=123. No further pulses over 30 cycles.
- Continue from 123, switch to 0x085, 0x105, 0x805 → `value`=999 after two complete scans, with a single pulse.
- Replace one tens sample with 0x1FF → `pattern_err` pulse and `err_count`=1. `value` holds 123, and there is no new pulse after recovery.
- Drive ones then hundreds (0x285, 0xE17) → `seq_err` pulse. `err_count` increments, and `match_cnt` resets so publication is delayed by two scans.
- Hold `seg_in`=0x000 → `stale` rises on cycle 16 and clears on the edge after the next completed scan. `value` is unchanged.
- Pull `RESET_N` low mid-scan, between edges → all outputs 0 asynchronously. After release, 123 is republished with a pulse.
